// File: rtl/fetch_queue_mw.sv
// Multi-lane in-order fetch queue between instruction memory and IF/ID.
// Up to LANES pushes and pops per cycle, show-ahead read, flush on redirect.
module fetch_queue_mw #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int LANES  = 2,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH + 1),
    parameter int LN_W   = $clog2(LANES + 1)
) (
    input  logic                    reloj,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [LN_W-1:0]         in_cnt,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [LANES*PC_W-1:0]   in_pc,
    output logic                    in_rdy,
    input  logic [LN_W-1:0]         out_req,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [LANES*PC_W-1:0]   out_pc,
    output logic [LANES-1:0]        out_valid,
    output logic [LN_W-1:0]         out_cnt,
    output logic [CNT_W-1:0]        count,
    output logic                    full,
    output logic                    empty,
    output logic                    ovf_err,
    output logic                    unf_err
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [PC_W-1:0]   mem_pc   [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [LN_W-1:0]   push_n;
    logic [LN_W-1:0]   req_n;
    logic [CNT_W-1:0]  push_amt;
    logic              push_ok;

    always_comb begin
        push_n = (in_cnt > LN_W'(LANES)) ? LN_W'(LANES) : in_cnt;
        req_n  = (out_req > LN_W'(LANES)) ? LN_W'(LANES) : out_req;
        // Room check uses registered count only: no out_req -> in_rdy path
        in_rdy   = (count <= CNT_W'(DEPTH - LANES));
        push_ok  = in_rdy && (push_n != '0);
        push_amt = push_ok ? CNT_W'(push_n) : '0;
        out_cnt  = (CNT_W'(req_n) > count) ? LN_W'(count) : req_n;
        full     = (count == CNT_W'(DEPTH));
        empty    = (count == '0);
    end

    always_comb begin
        out_data  = '0;
        out_pc    = '0;
        out_valid = '0;
        for (int i = 0; i < LANES; i++) begin
            if (CNT_W'(i) < count) begin
                out_valid[i] = 1'b1;
                out_data[i*DATA_W +: DATA_W] = mem_data[head + PTR_W'(i)];
                out_pc[i*PC_W +: PC_W]       = mem_pc[head + PTR_W'(i)];
            end
        end
    end

    always_ff @(posedge reloj) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                tail <= tail + PTR_W'(push_n);
            end
            head  <= head + PTR_W'(out_cnt);
            count <= count + push_amt - CNT_W'(out_cnt);
            if ((in_cnt != '0) && !in_rdy) begin
                ovf_err <= 1'b1;
            end
            if (CNT_W'(out_req) > count) begin
                unf_err <= 1'b1;
            end
        end
    end

    // Storage is intentionally not reset
    always_ff @(posedge reloj) begin
        if (!reset && !flush && push_ok) begin
            for (int i = 0; i < LANES; i++) begin
                if (LN_W'(i) < push_n) begin
                    mem_data[tail + PTR_W'(i)] <= in_data[i*DATA_W +: DATA_W];
                    mem_pc[tail + PTR_W'(i)]   <= in_pc[i*PC_W +: PC_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue_mw.sv
// Directed bench for fetch_queue_mw (LANES=2, DEPTH=8).
// Expected values are hand-computed from the instruction numbering n.
module tb_fetch_queue_mw;

    logic        reloj = 1'b0;
    logic        reset;
    logic        flush;
    logic [1:0]  in_cnt;
    logic [63:0] in_data;
    logic [63:0] in_pc;
    logic        in_rdy;
    logic [1:0]  out_req;
    logic [63:0] out_data;
    logic [63:0] out_pc;
    logic [1:0]  out_valid;
    logic [1:0]  out_cnt;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        ovf_err;
    logic        unf_err;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_queue_mw #(
        .DATA_W(32), .PC_W(32), .LANES(2), .DEPTH(8)
    ) dut (
        .reloj(reloj), .reset(reset), .flush(flush),
        .in_cnt(in_cnt), .in_data(in_data), .in_pc(in_pc),
        .in_rdy(in_rdy), .out_req(out_req),
        .out_data(out_data), .out_pc(out_pc),
        .out_valid(out_valid), .out_cnt(out_cnt),
        .count(count), .full(full), .empty(empty),
        .ovf_err(ovf_err), .unf_err(unf_err)
    );

    always #5 reloj = ~reloj;

    function automatic logic [31:0] ins(input int n);
        return 32'h2001_0000 + 32'(n);
    endfunction

    function automatic logic [31:0] pc4(input int n);
        return 32'h4 + 32'(4 * n);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge reloj);
        #1;
    endtask

    task automatic push2(input int n);
        in_cnt  = 2'd2;
        in_data = {ins(n + 1), ins(n)};
        in_pc   = {pc4(n + 1), pc4(n)};
    endtask

    task automatic push1(input int n);
        in_cnt  = 2'd1;
        in_data = {32'h0, ins(n)};
        in_pc   = {32'h0, pc4(n)};
    endtask

    task automatic idle();
        in_cnt  = 2'd0;
        out_req = 2'd0;
        flush   = 1'b0;
        reset   = 1'b0;
    endtask

    logic [31:0] old_l1;

    initial begin
        reset = 1'b1; flush = 1'b0;
        in_cnt = '0; out_req = '0; in_data = '0; in_pc = '0;
        tick();
        tick();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_in_rdy", 64'(in_rdy), 64'd1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_out_cnt", 64'(out_cnt), 64'd0);
        chk("rst_ovf", 64'(ovf_err), 64'd0);
        chk("rst_unf", 64'(unf_err), 64'd0);
        idle();

        // fill with n = 0..7
        for (int k = 0; k < 4; k++) begin
            push2(2 * k);
            tick();
        end
        idle();
        #1;
        chk("fill_count", 64'(count), 64'd8);
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_in_rdy", 64'(in_rdy), 64'd0);
        chk("fill_data", out_data, {ins(1), ins(0)});
        chk("fill_pc", out_pc, {pc4(1), pc4(0)});
        chk("fill_valid", 64'(out_valid), 64'd3);
        push2(100);
        tick();
        idle();
        #1;
        chk("ovf_set", 64'(ovf_err), 64'd1);
        chk("ovf_count", 64'(count), 64'd8);
        chk("ovf_data", out_data, {ins(1), ins(0)});

        // drain to 4, head = 4, tail = 0
        out_req = 2'd2;
        #1;
        chk("pop0_cnt", 64'(out_cnt), 64'd2);
        tick();
        chk("pop1_data", out_data, {ins(3), ins(2)});
        tick();
        idle();
        #1;
        chk("pop_count", 64'(count), 64'd4);
        chk("pop_unf", 64'(unf_err), 64'd0);

        // stream 10 cycles with wrap
        for (int k = 0; k < 10; k++) begin
            push2(8 + 2 * k);
            out_req = 2'd2;
            #1;
            chk("strm_data", out_data, {ins(5 + 2 * k), ins(4 + 2 * k)});
            chk("strm_cnt", 64'(out_cnt), 64'd2);
            tick();
        end
        idle();
        #1;
        chk("strm_count", 64'(count), 64'd4);
        chk("strm_head", out_data, {ins(25), ins(24)});
        chk("strm_pc", out_pc, {pc4(25), pc4(24)});

        // partial issue: 4 -> 3
        out_req = 2'd1;
        #1;
        chk("p1_cnt", 64'(out_cnt), 64'd1);
        tick();
        chk("p3_count", 64'(count), 64'd3);
        old_l1 = out_data[63:32];
        chk("p3_l1", 64'(old_l1), 64'(ins(26)));
        tick();
        chk("p2_count", 64'(count), 64'd2);
        chk("p2_head", 64'(out_data[31:0]), 64'(old_l1));
        tick();
        out_req = 2'd2;
        #1;
        chk("p1_count", 64'(count), 64'd1);
        chk("under_cnt", 64'(out_cnt), 64'd1);
        chk("under_valid", 64'(out_valid), 64'd1);
        chk("under_data", out_data, {32'h0, ins(27)});
        tick();
        idle();
        #1;
        chk("under_count", 64'(count), 64'd0);
        chk("under_empty", 64'(empty), 64'd1);
        chk("under_unf", 64'(unf_err), 64'd1);
        chk("under_vld0", 64'(out_valid), 64'd0);

        // flush with count = 5 and simultaneous push/pop
        push2(40);
        tick();
        push2(42);
        tick();
        push1(44);
        tick();
        idle();
        #1;
        chk("fl_pre_count", 64'(count), 64'd5);
        flush = 1'b1;
        push2(50);
        out_req = 2'd2;
        tick();
        idle();
        #1;
        chk("fl_count", 64'(count), 64'd0);
        chk("fl_empty", 64'(empty), 64'd1);
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_ovf_kept", 64'(ovf_err), 64'd1);
        chk("fl_unf_kept", 64'(unf_err), 64'd1);
        in_cnt  = 2'd1;
        in_data = {32'hFFFF_FFFF, 32'hDEAD_0000};
        in_pc   = {32'hFFFF_FFFF, 32'h0000_0100};
        tick();
        idle();
        #1;
        chk("fl_new_data", out_data, {32'h0, 32'hDEAD_0000});
        chk("fl_new_pc", out_pc, {32'h0, 32'h0000_0100});
        chk("fl_new_valid", 64'(out_valid), 64'd1);
        chk("fl_new_count", 64'(count), 64'd1);

        // reset mid-operation at count = 6
        push2(70);
        tick();
        push2(72);
        tick();
        push1(74);
        tick();
        idle();
        #1;
        chk("mr_pre_count", 64'(count), 64'd6);
        reset = 1'b1;
        push2(80);
        out_req = 2'd1;
        tick();
        idle();
        #1;
        chk("mr_count", 64'(count), 64'd0);
        chk("mr_empty", 64'(empty), 64'd1);
        chk("mr_full", 64'(full), 64'd0);
        chk("mr_in_rdy", 64'(in_rdy), 64'd1);
        chk("mr_valid", 64'(out_valid), 64'd0);
        chk("mr_out_cnt", 64'(out_cnt), 64'd0);
        chk("mr_ovf", 64'(ovf_err), 64'd0);
        chk("mr_unf", 64'(unf_err), 64'd0);
        push2(60);
        tick();
        idle();
        #1;
        chk("mr_resume_cnt", 64'(count), 64'd2);
        chk("mr_resume_data", out_data, {ins(61), ins(60)});
        chk("mr_resume_pc", out_pc, {pc4(61), pc4(60)});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
